color_order_scheduler: RTL and testbench

Sequencer that sits in front of the RGB dispensing timer (trigger / ciclos_R,G,B / flags) in the paint-dispenser datapath. It queues colour orders from the user-input block in a 4-deep FIFO and clamps each order's per-colour durations to the timer's range. It then fires the timer, waits for the blue-complete flag (with a watchdog) and runs a mixer phase. Finally it reports completion, one order at a time.

---
 rtl/color_sched_pkg.sv | 27 ++
 rtl/order_fifo.sv | 57 +++++
 rtl/color_order_scheduler.sv | 146 ++++++++++++++
 tb/tb_color_order_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_sched_pkg.sv
// Shared types and helpers for the colour-order scheduler: FSM states, the queued
// order record and the duration clamp applied on FIFO write.
package color_sched_pkg;

  localparam int MAX_CYC = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TRIG,
    WAIT_B,
    MIX,
    DONE,
    SETTLE
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } order_t;

  function automatic logic [4:0] clamp_cyc(input logic [4:0] v);
    return (v > 5'(MAX_CYC)) ? 5'(MAX_CYC) : v;
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous order FIFO with flush; a push while full is dropped, flush wins over
// push and pop in the same cycle.
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 15,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/color_order_scheduler.sv
// Queues colour orders and sequences the RGB dispensing timer: load durations,
// pulse trigger, wait for blue-done (with watchdog), run the mixer, report completion.
module color_order_scheduler
  import color_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MIX_CYCLES = 10,
  parameter int TIMEOUT    = 63
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     order_valid,
  output logic                     order_ready,
  input  logic [4:0]               order_r,
  input  logic [4:0]               order_g,
  input  logic [4:0]               order_b,
  input  logic                     abort,
  output logic                     trigger,
  output logic [4:0]               ciclos_R,
  output logic [4:0]               ciclos_G,
  output logic [4:0]               ciclos_B,
  input  logic [2:0]               flags,
  output logic                     mixer_on,
  output logic                     busy,
  output logic                     order_done,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int MW = $clog2(MIX_CYCLES + 1);

  state_t          state;
  state_t          next_state;
  logic            pop;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  order_t          wr_order;
  order_t          head;
  logic            flag_q;
  logic            blue_rise;
  logic            hold;
  logic [WW-1:0]   wd;
  logic            wd_expired;
  logic [MW-1:0]   mix_cnt;
  logic            unused_flags;

  // Handshake: an order transfers on a clock edge where order_valid && order_ready
  // and abort is low; order_ready is simply "FIFO not full" and never depends on order_valid.
  assign order_ready = !fifo_full;
  assign push        = order_valid && order_ready && !abort;
  assign wr_order    = '{r: clamp_cyc(order_r), g: clamp_cyc(order_g), b: clamp_cyc(order_b)};

  // Only blue-done drives sequencing; the red/green flags are informational.
  assign unused_flags = ^flags[2:1];
  assign blue_rise    = flags[0] && !flag_q;
  assign wd_expired   = (wd == WW'(TIMEOUT - 1));

  order_fifo #(.DEPTH(DEPTH), .W(15)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata (wr_order),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && !hold) begin
            next_state = LOAD;
            pop        = 1'b1;
          end
        end
        LOAD:   next_state = TRIG;
        TRIG:   next_state = WAIT_B;
        WAIT_B: begin
          if (blue_rise)       next_state = MIX;
          else if (wd_expired) next_state = IDLE;
        end
        MIX:    if (mix_cnt == '0) next_state = DONE;
        DONE:   next_state = SETTLE;
        SETTLE: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    trigger    = (state == TRIG);
    mixer_on   = (state == MIX);
    order_done = (state == DONE);
    busy       = (state != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ciclos_R <= '0;
      ciclos_G <= '0;
      ciclos_B <= '0;
      flag_q   <= 1'b0;
      wd       <= '0;
      mix_cnt  <= '0;
      error    <= 1'b0;
      hold     <= 1'b0;
    end else begin
      flag_q <= flags[0];

      if (pop) begin
        ciclos_R <= head.r;
        ciclos_G <= head.g;
        ciclos_B <= head.b;
      end

      if (state == TRIG)        wd <= '0;
      else if (state == WAIT_B) wd <= wd + WW'(1);

      if (state == WAIT_B && blue_rise)        mix_cnt <= MW'(MIX_CYCLES - 1);
      else if (state == MIX && mix_cnt != '0)  mix_cnt <= mix_cnt - MW'(1);

      if (abort)                                              error <= 1'b0;
      else if (state == WAIT_B && !blue_rise && wd_expired)   error <= 1'b1;

      // A timer started by TRIG keeps running after abort; wait for its flag to drop.
      if (abort && (state == TRIG || state == WAIT_B)) hold <= 1'b1;
      else if (!flags[0])                              hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_color_order_scheduler.sv
// Directed bench for color_order_scheduler: a behavioural timer model answers
// trigger pulses, and a monitor checks each trigger/order_done against expected queues.
module tb_color_order_scheduler;

  logic       clk;
  logic       reset;
  logic       order_valid;
  logic       order_ready;
  logic [4:0] order_r;
  logic [4:0] order_g;
  logic [4:0] order_b;
  logic       abort;
  logic       trigger;
  logic [4:0] ciclos_R;
  logic [4:0] ciclos_G;
  logic [4:0] ciclos_B;
  logic [2:0] flags;
  logic       mixer_on;
  logic       busy;
  logic       order_done;
  logic       error;
  logic [2:0] pending;

  logic [14:0] exp_q[$];
  logic [14:0] done_q[$];
  int n_checks;
  int n_pass;
  int tmr_mode;
  int tmr_delay;

  color_order_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .order_valid (order_valid),
    .order_ready (order_ready),
    .order_r     (order_r),
    .order_g     (order_g),
    .order_b     (order_b),
    .abort       (abort),
    .trigger     (trigger),
    .ciclos_R    (ciclos_R),
    .ciclos_G    (ciclos_G),
    .ciclos_B    (ciclos_B),
    .flags       (flags),
    .mixer_on    (mixer_on),
    .busy        (busy),
    .order_done  (order_done),
    .error       (error),
    .pending     (pending)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return trigger;
      1:       return mixer_on;
      2:       return order_done;
      default: return error;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_of(which) && n < limit);
    if (!sig_of(which)) check({name, "_timeout"}, 0, 1);
  endtask

  // driver: call at a negedge; presents one order for one cycle
  task automatic push_order(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b,
                            input logic [14:0] exp, input bit accept, input bit completes);
    order_valid = 1'b1;
    order_r = r;
    order_g = g;
    order_b = b;
    check("order_ready", 32'(order_ready), 32'(accept));
    if (accept) begin
      exp_q.push_back(exp);
      if (completes) done_q.push_back(exp);
    end
    @(negedge clk);
    order_valid = 1'b0;
  endtask

  // timer model: mode 0 normal, 1 never completes, 2 stale flag held then low then high
  initial begin : timer_model
    int tcnt;
    int lcnt;
    flags = 3'b000;
    tcnt = 0;
    lcnt = 0;
    forever begin
      @(negedge clk);
      if (trigger) begin
        tcnt = tmr_delay;
        lcnt = 0;
        if (tmr_mode != 2) flags = 3'b000;
      end else if (tcnt > 0) begin
        tcnt--;
        if (tcnt == 0) begin
          if (tmr_mode == 0) flags = 3'b111;
          else if (tmr_mode == 2) begin
            flags = 3'b000;
            lcnt = 3;
          end
        end
      end else if (lcnt > 0) begin
        lcnt--;
        if (lcnt == 0) flags = 3'b111;
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic        prev_trig;
    logic [14:0] e;
    int run, last_run, cyc, last_done_cyc;
    bit have_done;
    prev_trig = 1'b0;
    run = 0;
    last_run = 0;
    cyc = 0;
    last_done_cyc = 0;
    have_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mixer_on) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      if (trigger) begin
        check("trig_width", 32'(prev_trig), 0);
        if (have_done) check("trig_after_settle", 32'((cyc - last_done_cyc) >= 3), 1);
        have_done = 0;
        if (exp_q.size() == 0) check("unexpected_trigger", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("trig_ciclos", 32'({ciclos_R, ciclos_G, ciclos_B}), 32'(e));
        end
      end
      prev_trig = trigger;
      if (order_done) begin
        have_done = 1;
        last_done_cyc = cyc;
        check("mix_len", last_run, 10);
        last_run = 0;
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = done_q.pop_front();
          check("done_order", 32'({ciclos_R, ciclos_G, ciclos_B}), 32'(e));
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    n_checks = 0;
    n_pass = 0;
    tmr_mode = 0;
    tmr_delay = 12;
    reset = 1'b1;
    order_valid = 1'b0;
    order_r = '0;
    order_g = '0;
    order_b = '0;
    abort = 1'b0;

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_state", 32'({trigger, mixer_on, order_done, error, busy}), 0);
    check("rst_ready", 32'(order_ready), 1);
    check("rst_pending", 32'(pending), 0);
    check("rst_ciclos", 32'({ciclos_R, ciclos_G, ciclos_B}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // basic order, timer answers 12 cycles after trigger
    push_order(5'd3, 5'd2, 5'd1, {5'd3, 5'd2, 5'd1}, 1, 1);
    wait_for(0, 20, "basic_trig", n);
    wait_for(1, 40, "basic_mix", n);
    check("basic_trig_to_mix", n, 13);
    wait_for(2, 40, "basic_done", n);
    repeat (2) @(negedge clk);
    check("basic_idle_busy", 32'(busy), 0);

    // clamp and zero
    tmr_delay = 2;
    push_order(5'd20, 5'd0, 5'd31, {5'd15, 5'd0, 5'd15}, 1, 1);
    wait_for(2, 60, "clamp_done", n);
    repeat (2) @(negedge clk);

    // stale flag still high at trigger: completion needs a fresh low->high
    tmr_mode = 2;
    tmr_delay = 4;
    push_order(5'd5, 5'd6, 5'd7, {5'd5, 5'd6, 5'd7}, 1, 1);
    wait_for(0, 20, "stale_trig", n);
    wait_for(1, 40, "stale_mix", n);
    check("stale_trig_to_mix", n, 8);
    wait_for(2, 40, "stale_done", n);
    tmr_mode = 0;
    repeat (2) @(negedge clk);

    // FIFO full while the first order sits in WAIT_B
    tmr_delay = 25;
    push_order(5'd1, 5'd1, 5'd1, {5'd1, 5'd1, 5'd1}, 1, 1);
    wait_for(0, 20, "full_trig", n);
    repeat (2) @(negedge clk);
    push_order(5'd2, 5'd10, 5'd11, {5'd2, 5'd10, 5'd11}, 1, 1);
    push_order(5'd31, 5'd3, 5'd16, {5'd15, 5'd3, 5'd15}, 1, 1);
    push_order(5'd12, 5'd13, 5'd14, {5'd12, 5'd13, 5'd14}, 1, 1);
    push_order(5'd0, 5'd15, 5'd1, {5'd0, 5'd15, 5'd1}, 1, 1);
    check("full_pending", 32'(pending), 4);
    push_order(5'd7, 5'd7, 5'd7, {5'd7, 5'd7, 5'd7}, 0, 0);
    for (int i = 0; i < 5; i++) wait_for(2, 200, "full_done", n);
    repeat (2) @(negedge clk);
    check("full_drained", 32'({busy, pending}), 0);

    // watchdog: first order never completes, second still runs
    tmr_mode = 1;
    push_order(5'd4, 5'd4, 5'd4, {5'd4, 5'd4, 5'd4}, 1, 0);
    push_order(5'd6, 5'd6, 5'd6, {5'd6, 5'd6, 5'd6}, 1, 1);
    wait_for(0, 20, "wd_trig", n);
    wait_for(3, 100, "wd_error", n);
    check("wd_latency", n, 64);
    tmr_mode = 0;
    tmr_delay = 4;
    wait_for(2, 60, "wd_next_done", n);
    check("wd_error_sticky", 32'(error), 1);
    repeat (2) @(negedge clk);

    // abort mid-MIX with two orders queued
    tmr_delay = 3;
    push_order(5'd8, 5'd8, 5'd8, {5'd8, 5'd8, 5'd8}, 1, 1);
    push_order(5'd9, 5'd9, 5'd9, {5'd9, 5'd9, 5'd9}, 1, 1);
    push_order(5'd10, 5'd10, 5'd10, {5'd10, 5'd10, 5'd10}, 1, 1);
    wait_for(1, 40, "abort_mix", n);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    abort = 1'b0;
    check("abort_mixer", 32'(mixer_on), 0);
    check("abort_pending", 32'(pending), 0);
    check("abort_error", 32'(error), 0);
    check("abort_done", 32'(order_done), 0);
    repeat (20) @(negedge clk);
    check("abort_idle", 32'(busy), 0);

    // async reset while waiting on the timer
    tmr_mode = 1;
    push_order(5'd1, 5'd2, 5'd3, {5'd1, 5'd2, 5'd3}, 1, 0);
    wait_for(0, 20, "rst_trig", n);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_outputs", 32'({trigger, mixer_on, order_done, error, busy}), 0);
    check("arst_ciclos", 32'({ciclos_R, ciclos_G, ciclos_B}), 0);
    check("arst_pending", 32'(pending), 0);
    check("arst_ready", 32'(order_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
